// File: rtl/piso_serializer.sv
// Parallel-in / serial-out stage feeding a downstream serial register chain.
// Captures a word on valid/ready and emits it one bit per clock.
module piso_serializer #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n, shifted;
    logic [CW-1:0]    bit_cnt, bit_cnt_n;
    logic [3:0]       gap_cnt, gap_cnt_n;
    logic             sout_n, sout_valid_n, sout_last_n;
    logic             last_bit, accept;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign last_bit  = (state == SHIFT) && (bit_cnt == '0);
    assign din_ready = (state == IDLE) || (last_bit && GAP_CYCLES == 0);
    assign accept    = din_valid && din_ready;
    assign busy      = (state != IDLE);
    assign shifted   = MSB_FIRST ? (sreg << 1) : (sreg >> 1);

    always_comb begin
        state_n      = state;
        sreg_n       = sreg;
        bit_cnt_n    = bit_cnt;
        gap_cnt_n    = gap_cnt;
        sout_n       = IDLE_LEVEL;
        sout_valid_n = 1'b0;
        sout_last_n  = 1'b0;

        unique case (state)
            IDLE: ;
            SHIFT: begin
                if (bit_cnt != '0) begin
                    sreg_n       = shifted;
                    bit_cnt_n    = bit_cnt - CW'(1);
                    sout_n       = head(shifted);
                    sout_valid_n = 1'b1;
                    sout_last_n  = (bit_cnt == CW'(1));
                end else if (GAP_CYCLES > 0) begin
                    state_n   = GAP;
                    gap_cnt_n = 4'(GAP_CYCLES - 1);
                end else begin
                    state_n = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // A capture wins over the end-of-word transition (back-to-back words)
        if (accept) begin
            state_n      = SHIFT;
            sreg_n       = din;
            bit_cnt_n    = CW'(WIDTH - 1);
            sout_n       = head(din);
            sout_valid_n = 1'b1;
            sout_last_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            sout       <= IDLE_LEVEL;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
        end else begin
            state      <= state_n;
            sreg       <= sreg_n;
            bit_cnt    <= bit_cnt_n;
            gap_cnt    <= gap_cnt_n;
            sout       <= sout_n;
            sout_valid <= sout_valid_n;
            sout_last  <= sout_last_n;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations share one stimulus stream
// and are checked against a bit-list reference model plus directed sequences.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din;
    logic       din_valid;
    logic [2:0] rdy, so, sv, sl, by;
    logic [3:0] sipo = 4'b0;

    int n_cmp;
    int n_err;

    // Instance 0: MSB first, no gap. 1: LSB first, idle high. 2: MSB first, gap 2.
    logic [7:0] mbits [3];
    int         mlen  [3];
    int         mgap  [3];

    typedef struct {
        logic [3:0] din;
        logic [3:0] msb_seq;
        logic [3:0] lsb_seq;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    // Downstream 4-stage chain; sipo[0] is out1 (newest bit)
    always @(posedge clk) sipo <= {sipo[2:0], so[0]};

    piso_serializer #(
        .WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)
    ) u_msb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy[0]), .sout(so[0]), .sout_valid(sv[0]),
        .sout_last(sl[0]), .busy(by[0])
    );

    piso_serializer #(
        .WIDTH(4), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)
    ) u_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy[1]), .sout(so[1]), .sout_valid(sv[1]),
        .sout_last(sl[1]), .busy(by[1])
    );

    piso_serializer #(
        .WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)
    ) u_gap (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy[2]), .sout(so[2]), .sout_valid(sv[2]),
        .sout_last(sl[2]), .busy(by[2])
    );

    function automatic bit cfg_msb(input int i);
        return i != 1;
    endfunction

    function automatic int cfg_gap(input int i);
        return (i == 2) ? 2 : 0;
    endfunction

    function automatic bit cfg_idle(input int i);
        return i == 1;
    endfunction

    function automatic bit m_ready(input int i);
        return (mlen[i] == 0 && mgap[i] == 0) ||
               (mlen[i] == 1 && cfg_gap(i) == 0);
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            mbits[i] = '0;
            mlen[i]  = 0;
            mgap[i]  = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit acc;
            acc = din_valid && m_ready(i);
            if (mlen[i] > 0) begin
                mbits[i] = mbits[i] >> 1;
                mlen[i]--;
                if (mlen[i] == 0) mgap[i] = cfg_gap(i);
            end else if (mgap[i] > 0) begin
                mgap[i]--;
            end
            if (acc) begin
                for (int b = 0; b < 4; b++)
                    mbits[i][mlen[i] + b] = cfg_msb(i) ? din[3 - b] : din[b];
                mlen[i] += 4;
            end
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < 3; i++) begin
            logic v;
            v = (mlen[i] > 0);
            chk($sformatf("u%0d sout_valid", i), sv[i], v);
            chk($sformatf("u%0d sout", i), so[i], v ? mbits[i][0] : cfg_idle(i));
            chk($sformatf("u%0d sout_last", i), sl[i], mlen[i] == 1);
            chk($sformatf("u%0d busy", i), by[i], mlen[i] > 0 || mgap[i] > 0);
            chk($sformatf("u%0d din_ready", i), rdy[i], m_ready(i));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_clear();
        else model_edge();
        #1;
        model_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]  b2b;
        logic [10:0] gv, gr, gb;
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        model_clear();
        #2;
        model_check();
        chk("reset din_ready", rdy[0], 1'b1);
        #8 reset = 1'b0;

        tbl[0] = '{4'b1011, 4'b1011, 4'b1101};
        tbl[1] = '{4'b1100, 4'b1100, 4'b0011};
        tbl[2] = '{4'b0001, 4'b0001, 4'b1000};
        tbl[3] = '{4'b0110, 4'b0110, 4'b0110};
        tbl[4] = '{4'b1110, 4'b1110, 4'b0111};
        tbl[5] = '{4'b1000, 4'b1000, 4'b0001};

        for (int t = 0; t < 6; t++) begin
            din       = tbl[t].din;
            din_valid = 1'b1;
            step();
            din_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                chk("tbl msb bit", so[0], tbl[t].msb_seq[3 - k]);
                chk("tbl lsb bit", so[1], tbl[t].lsb_seq[3 - k]);
                chk("tbl gap bit", so[2], tbl[t].msb_seq[3 - k]);
                chk("tbl last", sl[0], k == 3);
                step();
            end
            chk("sipo out1", sipo[0], tbl[t].din[0]);
            chk("sipo out4", sipo[3], tbl[t].din[3]);
            chk("post sout", so[0], 1'b0);
            chk("post valid", sv[0], 1'b0);
            chk("post ready", rdy[0], 1'b1);
            step();
            step();
        end

        b2b       = 8'b1010_0101;
        din       = 4'hA;
        din_valid = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            chk("b2b sout", so[0], b2b[7 - k]);
            chk("b2b valid", sv[0], 1'b1);
            chk("b2b ready", rdy[0], (k % 4) == 3);
            if (k == 0) din = 4'h5;
            step();
            if (k == 3) din_valid = 1'b0;
        end
        chk("b2b end valid", sv[0], 1'b0);
        step();

        gv        = 11'b1111_000_1111;
        gr        = 11'b0000_001_0000;
        gb        = 11'b1111_110_1111;
        din       = 4'hA;
        din_valid = 1'b1;
        step();
        din = 4'h5;
        for (int k = 0; k < 11; k++) begin
            chk("gap valid", sv[2], gv[10 - k]);
            chk("gap ready", rdy[2], gr[10 - k]);
            chk("gap busy", by[2], gb[10 - k]);
            step();
            if (k == 6) din_valid = 1'b0;
        end
        step();
        step();

        din       = 4'hF;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("ign sout", so[0], 1'b1);
            chk("ign last", sl[0], k == 3);
            if (k == 1) begin
                din       = 4'h0;
                din_valid = 1'b1;
            end
            step();
            din_valid = 1'b0;
        end
        for (int j = 0; j < 3; j++) begin
            chk("ign idle valid", sv[0], 1'b0);
            step();
        end

        din       = 4'b1100;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        chk("rst bit1", so[0], 1'b1);
        step();
        chk("rst bit2", so[0], 1'b1);
        #2 reset = 1'b1;
        #1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            chk("rst async sout", so[i], cfg_idle(i));
            chk("rst async valid", sv[i], 1'b0);
            chk("rst async busy", by[i], 1'b0);
            chk("rst async ready", rdy[i], 1'b1);
        end
        @(negedge clk) reset = 1'b0;
        for (int j = 0; j < 6; j++) begin
            step();
            chk("rst no residue", sv[0], 1'b0);
        end

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 60) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end else begin
                din       = 4'($urandom);
                din_valid = ($urandom_range(0, 2) != 0);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
